// File: rtl/fb_rect_writer.sv
// Clipped rectangle fill engine for the framebuffer write port.
// It accepts one command and writes one palette index per clock, in row-major order.
module fb_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              wren_signal
);

    localparam logic [9:0]        H_X      = 10'(H_RES);
    localparam logic [8:0]        V_Y      = 9'(V_RES);
    localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL
    } state_t;

    state_t              state_q;
    logic [9:0]          x_q;
    logic [8:0]          y_q;
    logic [9:0]          w_q;
    logic [8:0]          h_q;
    logic [DATA_W-1:0]   color_q;
    logic [9:0]          w_eff_q;
    logic [8:0]          h_eff_q;
    logic [9:0]          col_q;
    logic [8:0]          row_q;
    logic [ADDR_W-1:0]   row_start_q;
    logic                fin_q;

    logic                empty_d;
    logic [9:0]          x_room_d;
    logic [8:0]          y_room_d;
    logic [9:0]          w_eff_d;
    logic [8:0]          h_eff_d;
    logic [ADDR_W-1:0]   y_ext;
    logic [ADDR_W-1:0]   y_scaled;
    logic [ADDR_W-1:0]   base_d;
    logic                row_end_d;
    logic                last_d;

    assign y_ext = ADDR_W'(y_q);

    // The 640-pixel stride is 512+128, so the row offset needs only two shifts.
    generate
        if (H_RES == 640) begin : g_shift_add
            assign y_scaled = (y_ext << 9) + (y_ext << 7);
        end else begin : g_const_mul
            assign y_scaled = y_ext * H_STRIDE;
        end
    endgenerate

    always_comb begin
        empty_d   = (x_q >= H_X) || (y_q >= V_Y) || (w_q == 10'd0) || (h_q == 9'd0);
        x_room_d  = H_X - x_q;
        y_room_d  = V_Y - y_q;
        w_eff_d   = (w_q < x_room_d) ? w_q : x_room_d;
        h_eff_d   = (h_q < y_room_d) ? h_q : y_room_d;
        base_d    = y_scaled + ADDR_W'(x_q);
        row_end_d = (col_q == w_eff_q - 10'd1);
        last_d    = row_end_d && (row_q == h_eff_q - 9'd1);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            w_eff_q     <= '0;
            h_eff_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_start_q <= '0;
            fin_q       <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            wren_signal <= 1'b0;
        end else begin
            done        <= 1'b0;
            wren_signal <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x_q       <= cmd_x;
                        y_q       <= cmd_y;
                        w_q       <= cmd_w;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // An empty command passes through FILL with fin already set,
                    // so done lands on the same edge a non-empty fill would start.
                    w_eff_q     <= w_eff_d;
                    h_eff_q     <= h_eff_d;
                    row_start_q <= base_d;
                    col_q       <= '0;
                    row_q       <= '0;
                    fin_q       <= empty_d;
                    state_q     <= ST_FILL;
                end
                ST_FILL: begin
                    if (fin_q) begin
                        fin_q     <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        wren_signal <= 1'b1;
                        write_addr  <= row_start_q + ADDR_W'(col_q);
                        write_data  <= color_q;
                        if (row_end_d) begin
                            col_q       <= '0;
                            row_q       <= row_q + 9'd1;
                            row_start_q <= row_start_q + H_STRIDE;
                        end else begin
                            col_q <= col_q + 10'd1;
                        end
                        // abort lets the write issued on this edge stand as the last one
                        if (last_d || abort) begin
                            fin_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
